// File: rtl/ysyx_23060221_wbu_pkg.sv
// Shared types and constants for the write-back stage.
// FSM encoding, the captured EXU bundle and fixed indices.
package ysyx_23060221_wbu_pkg;

    localparam int XLEN_D = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [4:0] A0_IDX = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMMIT  = 2'd1,
        S_HANDOFF = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN_D-1:0] wd;
        logic [4:0]        rd;
        logic              regwrite;
        logic [XLEN_D-1:0] pc;
        logic [XLEN_D-1:0] imm;
        logic [XLEN_D-1:0] src1;
        logic              pca;
        logic              pcb;
        logic              ebreak;
    } exu_wbu_t;

endpackage

// File: rtl/ysyx_23060221_wbu_if.sv
// Handshake bundles around the write-back stage.
// in_if: EXU -> WBU result channel; out_if: WBU -> IFU next-PC channel.
interface ysyx_23060221_wbu_in_if;
    logic        EXU_valid;
    logic        WBU_ready;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        regwrite;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] src1;
    logic        PCAsrc;
    logic        PCBsrc;
    logic        ebreak;

    modport master (
        output EXU_valid, wd, rd, regwrite, pc, imm, src1,
        output PCAsrc, PCBsrc, ebreak,
        input  WBU_ready
    );
    modport slave (
        input  EXU_valid, wd, rd, regwrite, pc, imm, src1,
        input  PCAsrc, PCBsrc, ebreak,
        output WBU_ready
    );
endinterface

interface ysyx_23060221_wbu_out_if;
    logic        WBU_valid;
    logic        IFU_ready;
    logic [31:0] dnpc;

    modport master (output WBU_valid, dnpc, input IFU_ready);
    modport slave  (input WBU_valid, dnpc, output IFU_ready);
endinterface

// File: rtl/ysyx_23060221_gpr.sv
// Architectural GPR file: 1 write port, 2 async read ports, a0 tap.
// x0 and indices >= NR_GPR read as zero; writes to them are dropped.
module ysyx_23060221_gpr #(
    parameter int NR_GPR = 32,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] a0
);
    import ysyx_23060221_wbu_pkg::*;

    localparam int AW = $clog2(NR_GPR);
    localparam logic [5:0] NR = 6'(NR_GPR);

    logic [XLEN-1:0] regs [NR_GPR];

    function automatic logic live(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < NR);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_GPR; i++) regs[i] <= '0;
        end else if (we && live(waddr)) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    // No write bypass: a same-cycle read sees the pre-commit value.
    assign rdata1 = live(raddr1) ? regs[raddr1[AW-1:0]] : '0;
    assign rdata2 = live(raddr2) ? regs[raddr2[AW-1:0]] : '0;
    assign a0     = regs[A0_IDX[AW-1:0]];

endmodule

// File: rtl/ysyx_23060221_wbu.sv
// Write-back stage: commits EXU results, computes next PC, hands it to IFU.
// Ports: exu (EXU handshake), ifu (dnpc handshake), GPR reads, halt, retire_cnt.
module ysyx_23060221_wbu #(
    parameter logic [31:0] RESET_PC = ysyx_23060221_wbu_pkg::RESET_PC,
    parameter int          NR_GPR   = 32,
    parameter int          XLEN     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_23060221_wbu_in_if.slave  exu,
    ysyx_23060221_wbu_out_if.master ifu,
    input  logic [4:0]             raddr1,
    input  logic [4:0]             raddr2,
    output logic [XLEN-1:0]        rdata1,
    output logic [XLEN-1:0]        rdata2,
    output logic                   halt,
    output logic [XLEN-1:0]        halt_code,
    output logic [63:0]            retire_cnt
);
    import ysyx_23060221_wbu_pkg::*;

    state_t state, state_nx;
    exu_wbu_t hold;
    logic [31:0] dnpc_q;
    logic [31:0] base, off, sum, npc;
    logic [XLEN-1:0] a0_cur, a0_post;
    logic gpr_we;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (exu.EXU_valid) state_nx = S_COMMIT;
            S_COMMIT:  state_nx = hold.ebreak ? S_HALT : S_HANDOFF;
            S_HANDOFF: if (ifu.IFU_ready) state_nx = S_IDLE;
            S_HALT:    state_nx = S_HALT;
            default:   state_nx = S_IDLE;
        endcase
    end

    assign exu.WBU_ready = (state == S_IDLE);
    assign ifu.WBU_valid = (state == S_HANDOFF);
    assign ifu.dnpc      = dnpc_q;

    // jalr clears bit 0 of the target.
    assign base = hold.pcb ? hold.src1 : hold.pc;
    assign off  = hold.pca ? hold.imm : 32'd4;
    assign sum  = base + off;
    assign npc  = {sum[31:1], sum[0] & ~hold.pcb};

    assign gpr_we  = (state == S_COMMIT) && hold.regwrite;
    assign a0_post = (hold.regwrite && hold.rd == A0_IDX)
                   ? hold.wd : a0_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            dnpc_q     <= RESET_PC;
            halt       <= 1'b0;
            halt_code  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state == S_IDLE && exu.EXU_valid) begin
                hold.wd       <= exu.wd;
                hold.rd       <= exu.rd;
                hold.regwrite <= exu.regwrite;
                hold.pc       <= exu.pc;
                hold.imm      <= exu.imm;
                hold.src1     <= exu.src1;
                hold.pca      <= exu.PCAsrc;
                hold.pcb      <= exu.PCBsrc;
                hold.ebreak   <= exu.ebreak;
            end
            if (state == S_COMMIT) begin
                dnpc_q     <= npc;
                retire_cnt <= retire_cnt + 64'd1;
                if (hold.ebreak) begin
                    halt      <= 1'b1;
                    halt_code <= a0_post;
                end
            end
        end
    end

    ysyx_23060221_gpr #(.NR_GPR(NR_GPR), .XLEN(XLEN)) u_gpr (
        .clk    (clk),
        .rst    (rst),
        .we     (gpr_we),
        .waddr  (hold.rd),
        .wdata  (hold.wd),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .a0     (a0_cur)
    );

endmodule

// File: tb/tb_ysyx_23060221_wbu.sv
// Bench for ysyx_23060221_wbu: directed vectors, dnpc scoreboard.
// Expected dnpc pushed at issue; monitor pops on each WBU->IFU handshake.
module tb_ysyx_23060221_wbu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] raddr1 = '0;
    logic [4:0] raddr2 = '0;
    logic [31:0] rdata1, rdata2, halt_code;
    logic halt;
    logic [63:0] retire_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] expq [$];

    ysyx_23060221_wbu_in_if  exu_if ();
    ysyx_23060221_wbu_out_if ifu_if ();

    ysyx_23060221_wbu dut (
        .clk        (clk),
        .rst        (rst),
        .exu        (exu_if),
        .ifu        (ifu_if),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .halt       (halt),
        .halt_code  (halt_code),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every dnpc handoff is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ifu_if.WBU_valid && ifu_if.IFU_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_handoff", {32'd0, ifu_if.dnpc}, 64'd0 - 64'd1);
            end else begin
                chk("dnpc", {32'd0, ifu_if.dnpc}, {32'd0, expq.pop_front()});
            end
        end
    end

    task automatic issue(input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] src1,
                         input logic pca, input logic pcb, input logic eb,
                         input logic [31:0] exp_dnpc);
        int n = 0;
        while (!exu_if.WBU_ready && n < 50) begin
            step(1);
            n++;
        end
        if (!exu_if.WBU_ready) chk("issue_timeout", 64'd0, 64'd1);
        exu_if.wd       = wd;
        exu_if.rd       = rd;
        exu_if.regwrite = rw;
        exu_if.pc       = pc;
        exu_if.imm      = imm;
        exu_if.src1     = src1;
        exu_if.PCAsrc   = pca;
        exu_if.PCBsrc   = pcb;
        exu_if.ebreak   = eb;
        exu_if.EXU_valid = 1'b1;
        if (!eb) expq.push_back(exp_dnpc);
        step(1);
        exu_if.EXU_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        exu_if.EXU_valid = 1'b0;
        exu_if.wd = '0; exu_if.rd = '0; exu_if.regwrite = 1'b0;
        exu_if.pc = '0; exu_if.imm = '0; exu_if.src1 = '0;
        exu_if.PCAsrc = 1'b0; exu_if.PCBsrc = 1'b0; exu_if.ebreak = 1'b0;
        ifu_if.IFU_ready = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);

        // reset state
        raddr1 = 5'd5;
        chk("rst_ready", {63'd0, exu_if.WBU_ready}, 64'd1);
        chk("rst_valid", {63'd0, ifu_if.WBU_valid}, 64'd0);
        chk("rst_dnpc", {32'd0, ifu_if.dnpc}, 64'h8000_0000);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_code", {32'd0, halt_code}, 64'd0);
        chk("rst_retire", retire_cnt, 64'd0);
        chk("rst_x5", {32'd0, rdata1}, 64'd0);

        // ALU commit
        issue(32'h1234, 5'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 32'h8000_0004);
        chk("alu_ready_low", {63'd0, exu_if.WBU_ready}, 64'd0);
        chk("alu_x5_old", {32'd0, rdata1}, 64'd0);
        step(1);
        chk("alu_x5_new", {32'd0, rdata1}, 64'h1234);
        chk("alu_valid", {63'd0, ifu_if.WBU_valid}, 64'd1);
        chk("alu_retire", retire_cnt, 64'd1);

        // branch taken, no write
        raddr2 = 5'd6;
        issue(32'hDEAD, 5'd6, 1'b0, 32'h8000_0010, 32'hFFFF_FFF0, 32'd0,
              1'b1, 1'b0, 1'b0, 32'h8000_0000);
        step(1);
        chk("br_x6", {32'd0, rdata2}, 64'd0);

        // jalr: bit 0 cleared, link written
        raddr1 = 5'd1;
        issue(32'h8000_0008, 5'd1, 1'b1, 32'h8000_0020, 32'd4, 32'h8000_0101,
              1'b1, 1'b1, 1'b0, 32'h8000_0104);
        step(1);
        chk("jalr_x1", {32'd0, rdata1}, 64'h8000_0008);

        // x0 stays zero; same-cycle read of rd returns old value
        issue(32'h77, 5'd7, 1'b1, 32'h8000_0100, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 32'h8000_0104);
        raddr1 = 5'd0;
        issue(32'hFFFF_FFFF, 5'd0, 1'b1, 32'h8000_0104, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 32'h8000_0108);
        step(1);
        chk("x0_zero", {32'd0, rdata1}, 64'd0);
        raddr2 = 5'd7;
        issue(32'h99, 5'd7, 1'b1, 32'h8000_0108, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 32'h8000_010C);
        chk("x7_old", {32'd0, rdata2}, 64'h77);
        step(1);
        chk("x7_new", {32'd0, rdata2}, 64'h99);

        // backpressure with a stray EXU_valid pulse
        step(2);
        ifu_if.IFU_ready = 1'b0;
        issue(32'h55, 5'd8, 1'b1, 32'h8000_0200, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 32'h8000_0204);
        step(1);
        raddr2 = 5'd9;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, ifu_if.WBU_valid}, 64'd1);
            chk("bp_dnpc", {32'd0, ifu_if.dnpc}, 64'h8000_0204);
            chk("bp_ready", {63'd0, exu_if.WBU_ready}, 64'd0);
            if (i == 1) begin
                exu_if.wd = 32'hBAD; exu_if.rd = 5'd9; exu_if.regwrite = 1'b1;
                exu_if.EXU_valid = 1'b1;
            end else begin
                exu_if.EXU_valid = 1'b0;
            end
            step(1);
        end
        chk("bp_x9", {32'd0, rdata2}, 64'd0);
        chk("bp_retire", retire_cnt, 64'd7);
        ifu_if.IFU_ready = 1'b1;
        step(2);

        // ebreak with a0 = 0
        issue(32'd0, 5'd0, 1'b0, 32'h8000_0300, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("halt_novalid", {63'd0, ifu_if.WBU_valid}, 64'd0);
            step(1);
        end
        chk("halt_set", {63'd0, halt}, 64'd1);
        chk("halt_code0", {32'd0, halt_code}, 64'd0);
        chk("halt_ready", {63'd0, exu_if.WBU_ready}, 64'd0);
        chk("halt_retire", retire_cnt, 64'd8);

        // one-cycle reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        raddr1 = 5'd5;
        chk("rst2_halt", {63'd0, halt}, 64'd0);
        chk("rst2_dnpc", {32'd0, ifu_if.dnpc}, 64'h8000_0000);
        chk("rst2_retire", retire_cnt, 64'd0);
        chk("rst2_x5", {32'd0, rdata1}, 64'd0);
        chk("rst2_ready", {63'd0, exu_if.WBU_ready}, 64'd1);

        // ebreak that also writes a0: halt_code sees post-commit value
        issue(32'h2A, 5'd10, 1'b1, 32'h8000_0000, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b1, 32'd0);
        step(2);
        chk("halt_code_a0", {32'd0, halt_code}, 64'h2A);
        chk("halt2_retire", retire_cnt, 64'd1);
        chk("sb_empty", {32'd0, 32'(expq.size())}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
